// File: rtl/vs_uart_pkg.sv
// vs_uart_pkg: parity mode constants, TX/RX state types and the parity helper
// shared by the vs_uart_param core.
package vs_uart_pkg;

  localparam int unsigned PAR_NONE      = 0;
  localparam int unsigned PAR_EVEN      = 1;
  localparam int unsigned PAR_ODD       = 2;
  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    TxIdle,
    TxWtick,
    TxStart,
    TxData,
    TxPar,
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxPar,
    RxStop,
    RxWend
  } rx_state_e;

  // Even parity is the XOR of the data; odd parity is its inverse. Callers
  // zero-extend narrower data, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input int unsigned mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/vs_uart_param_if.sv
// vs_uart_param_if: pin-level serial lines plus the RX consumer and TX producer
// byte-stream handshakes. The slave modport is the UART core side.
interface vs_uart_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rxd;
  logic                 txd;
  logic                 rx_data_en;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_par_err;
  logic                 rx_frm_err;
  logic                 tx_rdy_t;
  logic [DATA_BITS-1:0] tx_data_r;
  logic                 tx_rdy_r;

  modport master (
    output rxd, tx_rdy_t, tx_data_r,
    input  txd, rx_data_en, rx_data, rx_par_err, rx_frm_err, tx_rdy_r
  );

  modport slave (
    input  rxd, tx_rdy_t, tx_data_r,
    output txd, rx_data_en, rx_data, rx_par_err, rx_frm_err, tx_rdy_r
  );
endinterface

// File: rtl/vs_uart_tick.sv
// vs_uart_tick: free-running oversample tick generator, one clock-wide pulse
// every DIV clocks.
module vs_uart_tick #(
  parameter int unsigned DIV = 868
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_ceo
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign o_ceo  = w_wrap;

  // Divider counter, cleared explicitly on the tick cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/vs_uart_param.sv
// vs_uart_param: parametrised full-duplex UART core. Independent TX and RX FSMs
// share only the oversample tick.
// Build macro UART_RX_MAJORITY_EN: each RX sample becomes the 2-of-3 majority of
// ticks OSR/2-1, OSR/2 and OSR/2+1 (decision on OSR/2+1); otherwise a single
// sample is taken at tick OSR/2.
module vs_uart_param
  import vs_uart_pkg::*;
#(
  parameter int unsigned DIV       = 868,
  parameter int unsigned OSR       = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 1,
  parameter int unsigned STOP_BITS = 2,
  parameter int unsigned SYNC_W    = 3
) (
  input logic            i_clk,
  input logic            i_rst_n,
  vs_uart_param_if.slave bus
);
  localparam int unsigned TCW  = $clog2(OSR);
  localparam int unsigned BCW  = $clog2(DATA_BITS + 1);
  localparam int unsigned SAMP = OSR / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned RX_DEC = SAMP + 1;
`else
  localparam int unsigned RX_DEC = SAMP;
`endif

  logic w_tick;

  vs_uart_tick #(.DIV(DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .o_ceo  (w_tick)
  );

  // ---------------------------------------------------------------- TX
  tx_state_e            r_tx_state, w_tx_state;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift;
  logic                 r_tx_par, w_tx_par;
  logic [TCW-1:0]       r_tx_tcnt, w_tx_tcnt;
  logic [BCW-1:0]       r_tx_bcnt, w_tx_bcnt;
  logic                 r_txd, w_txd;
  logic                 r_tx_rdy, w_tx_rdy;
  logic                 w_tx_bit_end;

  assign w_tx_bit_end = w_tick && (r_tx_tcnt == TCW'(OSR - 1));

  // TX state and datapath registers; reset forces the line idle at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_state <= TxIdle;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_tcnt  <= '0;
      r_tx_bcnt  <= '0;
      r_txd      <= 1'b1;
      r_tx_rdy   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_shift <= w_tx_shift;
      r_tx_par   <= w_tx_par;
      r_tx_tcnt  <= w_tx_tcnt;
      r_tx_bcnt  <= w_tx_bcnt;
      r_txd      <= w_txd;
      r_tx_rdy   <= w_tx_rdy;
    end
  end

  // TX next state: each bit spans OSR ticks, the line value is registered.
  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_shift = r_tx_shift;
    w_tx_par   = r_tx_par;
    w_tx_tcnt  = r_tx_tcnt;
    w_tx_bcnt  = r_tx_bcnt;
    w_txd      = r_txd;
    w_tx_rdy   = r_tx_rdy;
    if (r_tx_state != TxIdle && r_tx_state != TxWtick && w_tick) begin
      w_tx_tcnt = w_tx_bit_end ? '0 : r_tx_tcnt + 1'b1;
    end
    unique case (r_tx_state)
      TxIdle: begin
        if (bus.tx_rdy_t && r_tx_rdy) begin
          w_tx_shift = bus.tx_data_r;
          w_tx_par   = calc_parity(MAX_DATA_BITS'(bus.tx_data_r), PARITY);
          w_tx_rdy   = 1'b0;
          w_tx_state = TxWtick;
        end
      end
      TxWtick: begin
        if (w_tick) begin
          w_txd      = 1'b0;
          w_tx_tcnt  = '0;
          w_tx_state = TxStart;
        end
      end
      TxStart: begin
        if (w_tx_bit_end) begin
          w_txd      = r_tx_shift[0];
          w_tx_shift = r_tx_shift >> 1;
          w_tx_bcnt  = '0;
          w_tx_state = TxData;
        end
      end
      TxData: begin
        if (w_tx_bit_end) begin
          if (r_tx_bcnt == BCW'(DATA_BITS - 1)) begin
            w_tx_bcnt = '0;
            if (PARITY != PAR_NONE) begin
              w_txd      = r_tx_par;
              w_tx_state = TxPar;
            end else begin
              w_txd      = 1'b1;
              w_tx_state = TxStop;
            end
          end else begin
            w_txd      = r_tx_shift[0];
            w_tx_shift = r_tx_shift >> 1;
            w_tx_bcnt  = r_tx_bcnt + 1'b1;
          end
        end
      end
      TxPar: begin
        if (w_tx_bit_end) begin
          w_txd      = 1'b1;
          w_tx_bcnt  = '0;
          w_tx_state = TxStop;
        end
      end
      TxStop: begin
        if (w_tx_bit_end) begin
          if (r_tx_bcnt == BCW'(STOP_BITS - 1)) begin
            w_tx_rdy   = 1'b1;
            w_tx_bcnt  = '0;
            w_tx_state = TxIdle;
          end else begin
            w_tx_bcnt = r_tx_bcnt + 1'b1;
          end
        end
      end
      default: w_tx_state = TxIdle;
    endcase
  end

  assign bus.txd      = r_txd;
  assign bus.tx_rdy_r = r_tx_rdy;

  // ---------------------------------------------------------------- RX
  logic [SYNC_W-1:0]    r_sync;
  logic                 w_rxd;
  logic                 w_rx_bit;
  logic                 w_rx_samp;
  rx_state_e            r_rx_state, w_rx_state;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift;
  logic [TCW-1:0]       r_rx_tcnt, w_rx_tcnt;
  logic [BCW-1:0]       r_rx_bcnt, w_rx_bcnt;
  logic                 r_rx_perr, w_rx_perr;
  logic                 r_rx_ferr, w_rx_ferr;
  logic                 w_ferr_now;
  logic [DATA_BITS-1:0] r_rx_data, w_rx_data;
  logic                 r_rx_perr_o, w_rx_perr_o;
  logic                 r_rx_ferr_o, w_rx_ferr_o;
  logic                 r_rx_en, w_rx_en;

  assign w_rxd     = r_sync[SYNC_W-1];
  assign w_rx_samp = w_tick && (r_rx_tcnt == TCW'(RX_DEC));

  // RXD synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '1;
    else          r_sync <= {r_sync[SYNC_W-2:0], bus.rxd};
  end

`ifdef UART_RX_MAJORITY_EN
  logic r_maj_a, r_maj_b;

  // Capture the two samples that precede the decision tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_maj_a <= 1'b1;
      r_maj_b <= 1'b1;
    end else if (w_tick) begin
      if (r_rx_tcnt == TCW'(SAMP - 1)) r_maj_a <= w_rxd;
      if (r_rx_tcnt == TCW'(SAMP))     r_maj_b <= w_rxd;
    end
  end

  assign w_rx_bit = (r_maj_a & r_maj_b) | (r_maj_a & w_rxd) | (r_maj_b & w_rxd);
`else
  assign w_rx_bit = w_rxd;
`endif

  // RX state, datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_state  <= RxIdle;
      r_rx_shift  <= '0;
      r_rx_tcnt   <= '0;
      r_rx_bcnt   <= '0;
      r_rx_perr   <= 1'b0;
      r_rx_ferr   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_perr_o <= 1'b0;
      r_rx_ferr_o <= 1'b0;
      r_rx_en     <= 1'b0;
    end else begin
      r_rx_state  <= w_rx_state;
      r_rx_shift  <= w_rx_shift;
      r_rx_tcnt   <= w_rx_tcnt;
      r_rx_bcnt   <= w_rx_bcnt;
      r_rx_perr   <= w_rx_perr;
      r_rx_ferr   <= w_rx_ferr;
      r_rx_data   <= w_rx_data;
      r_rx_perr_o <= w_rx_perr_o;
      r_rx_ferr_o <= w_rx_ferr_o;
      r_rx_en     <= w_rx_en;
    end
  end

  // RX next state: the tick counter runs from start detection and wraps every
  // OSR ticks, so every decision lands at the same offset within its bit.
  always_comb begin
    w_rx_state  = r_rx_state;
    w_rx_shift  = r_rx_shift;
    w_rx_tcnt   = r_rx_tcnt;
    w_rx_bcnt   = r_rx_bcnt;
    w_rx_perr   = r_rx_perr;
    w_rx_ferr   = r_rx_ferr;
    w_rx_data   = r_rx_data;
    w_rx_perr_o = r_rx_perr_o;
    w_rx_ferr_o = r_rx_ferr_o;
    w_rx_en     = 1'b0;
    w_ferr_now  = r_rx_ferr | ~w_rx_bit;
    if (r_rx_state != RxIdle && r_rx_state != RxWend && w_tick) begin
      w_rx_tcnt = (r_rx_tcnt == TCW'(OSR - 1)) ? '0 : r_rx_tcnt + 1'b1;
    end
    unique case (r_rx_state)
      RxIdle: begin
        if (!w_rxd) begin
          w_rx_tcnt  = '0;
          w_rx_state = RxStart;
        end
      end
      RxStart: begin
        if (w_rx_samp) begin
          if (w_rx_bit) begin
            w_rx_state = RxIdle;  // glitch: no frame
          end else begin
            w_rx_bcnt  = '0;
            w_rx_perr  = 1'b0;
            w_rx_state = RxData;
          end
        end
      end
      RxData: begin
        if (w_rx_samp) begin
          w_rx_shift = {w_rx_bit, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_bcnt == BCW'(DATA_BITS - 1)) begin
            w_rx_bcnt = '0;
            w_rx_ferr = 1'b0;
            w_rx_state = (PARITY != PAR_NONE) ? RxPar : RxStop;
          end else begin
            w_rx_bcnt = r_rx_bcnt + 1'b1;
          end
        end
      end
      RxPar: begin
        if (w_rx_samp) begin
          w_rx_perr  = w_rx_bit != calc_parity(MAX_DATA_BITS'(r_rx_shift), PARITY);
          w_rx_state = RxStop;
        end
      end
      RxStop: begin
        if (w_rx_samp) begin
          w_rx_ferr = w_ferr_now;
          if (r_rx_bcnt == BCW'(STOP_BITS - 1)) begin
            w_rx_data   = r_rx_shift;
            w_rx_perr_o = r_rx_perr;
            w_rx_ferr_o = w_ferr_now;
            w_rx_en     = 1'b1;
            w_rx_bcnt   = '0;
            // A line still low here is a break; wait for it to return high.
            w_rx_state  = w_rxd ? RxIdle : RxWend;
          end else begin
            w_rx_bcnt = r_rx_bcnt + 1'b1;
          end
        end
      end
      RxWend: begin
        if (w_rxd) w_rx_state = RxIdle;
      end
      default: w_rx_state = RxIdle;
    endcase
  end

  assign bus.rx_data_en = r_rx_en;
  assign bus.rx_data    = r_rx_data;
  assign bus.rx_par_err = r_rx_perr_o;
  assign bus.rx_frm_err = r_rx_ferr_o;
endmodule

// File: doc/vs_uart_param.md
# vs_uart_param

Parametrised full-duplex UART core: a configurable-format successor to the fixed 8E2 UART. Frame format (data width, parity mode, stop-bit count), oversampling ratio and baud divider are set at elaboration. It adds RX parity/framing error flags and a start-bit glitch filter. It sits between the pin-level RXD/TXD and the byte-stream producer/consumer blocks: STP on the RX side, DRP on the TX side.

## Interface
- DIV, 868: system clocks per oversample tick (≥2)
- OSR, 16: oversample ticks per bit (even, 8..32)
- DATA_BITS, 8: data bits per frame (5..9)
- PARITY, 1: 0 none, 1 even, 2 odd
- STOP_BITS, 2: stop bits (1 or 2)
- SYNC_W, 3: RXD synchroniser depth (≥2)
- CLK  in  1  system clock; single clock domain
- RST_N  in  1  reset, asynchronous, active-low
- RXD  in  1  serial input, asynchronous to CLK
- TXD  out  1  serial output, idle high
- RX_DATA_EN  out  1  one-cycle pulse: received frame valid
- RX_DATA  out  DATA_BITS  received data, LSB first on the line
- RX_PAR_ERR  out  1  parity mismatch on the last frame (always 0 when PARITY=0)
- RX_FRM_ERR  out  1  a stop bit sampled low on the last frame
- TX_RDY_T  in  1  producer has data valid
- TX_DATA_R  in  DATA_BITS  data to send
- TX_RDY_R  out  1  transmitter ready to accept

## Operation
- Reset values: TXD=1, TX_RDY_R=1, RX_DATA_EN=0, RX_DATA=0, both error flags 0, synchroniser all 1s, both FSMs IDLE, all counters 0.
- Tick generator: free-running; one CLK-wide pulse every DIV clocks.
- TX FSM states: IDLE → WTICK → START → DATA → PAR (skipped if PARITY=0) → STOP → IDLE.
  - Accept: TX_RDY_T & TX_RDY_R at a CLK edge. The core latches data, computes parity (even: XOR of data; odd: its inverse), and drops TX_RDY_R.
  - WTICK: waits for the next tick, then drives TXD=0.
  - Each bit lasts exactly OSR ticks.
  - DATA shifts out DATA_BITS bits, LSB first.
  - STOP drives 1 for STOP_BITS×OSR ticks. TX_RDY_R rises on the tick that ends the last stop bit.
- RX FSM states: IDLE → START → DATA → PAR → STOP → (WEND) → IDLE.
  - Input is the synchronised RXD_RG (SYNC_W-stage shift register).
  - IDLE: RXD_RG=0 clears the tick counter and enters START.
  - START: at tick OSR/2, RXD_RG=1 counts as a glitch and returns to IDLE with no output. RXD_RG=0 enters DATA.
  - Later samples fall every OSR ticks, at bit centre.
  - DATA shifts in DATA_BITS bits.
  - PAR compares the received parity bit against the computed parity.
  - STOP samples each stop bit. Any low sample sets the frame-error condition.
  - At the centre of the last stop bit:
    - update RX_DATA and both flags, pulse RX_DATA_EN for one cycle;
    - go to IDLE if RXD_RG=1, else WEND;
    - WEND holds until RXD_RG=1, so a held-low (break) line never re-triggers a start.
- RX_DATA and error flags hold until the next RX_DATA_EN.
- TX and RX are fully independent. Simultaneous activity and shared ticks have no interaction.
- Reset asserted mid-frame aborts both FSMs at once. TXD returns to 1 asynchronously and no RX_DATA_EN is issued.
- Counter widths: $clog2(DIV), $clog2(OSR), $clog2(DATA_BITS+1). All counters wrap only through an explicit clear.

## Timing
- TX accept → TX_RDY_R low: 1 cycle.
- TX accept → TXD falling: 1 to DIV+1 cycles.
- TX frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × OSR × DIV cycles.
- RX latency: RXD edge → RXD_RG after SYNC_W cycles. RX_DATA_EN fires in the cycle after the mid-last-stop-bit tick.
- A new TX accept is possible in the cycle after TX_RDY_R rises.

## Configuration
- UART_RX_MAJORITY_EN:
  - Defined: each RX sample is the 2-of-3 majority of ticks OSR/2-1, OSR/2 and OSR/2+1 within the bit. This applies to the start-bit check too.
  - Undefined: single sample at tick OSR/2.
  - Frame timing and outputs are otherwise identical.

## Structure
- Package vs_uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - TX and RX state enums;
  - a parity function.
- Sub-module vs_uart_tick (parameter DIV; ports CLK, RST_N, CEO) is the tick generator.
- Everything else lives in vs_uart_param.

## Test plan
- Defaults with DIV=4, OSR=16; send 0xA5:
  - TXD = 0, then 1,0,1,0,0,1,0,1, then parity 0, then 1,1;
  - each bit 64 cycles;
  - TX_RDY_R low for 768 cycles, plus up to 5 cycles of tick alignment.
- TXD looped to RXD, 0x00/0xFF/0x5A back-to-back: three RX_DATA_EN pulses with matching data and flags 0.
- RX frame 0x3C (even parity, four ones, so correct parity bit is 0) driven with parity bit 1: RX_DATA=0x3C, RX_PAR_ERR=1.
- Second stop bit driven low, line held low 5 bit-times: one RX_DATA_EN with RX_FRM_ERR=1, then no further pulse until the line returns high.
- 3-tick low glitch on an idle RXD: no RX_DATA_EN, RX FSM back in IDLE.
- DATA_BITS=7, PARITY=2, STOP_BITS=1, send 0x41: TXD = 0, 1000001, parity 1, 1. Also assert RST_N low mid-data: TXD=1 and TX_RDY_R=1 immediately, and no RX pulse.
